// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, controller states and control-strobe bundle
//
// Purpose: common definitions for the microcode controller of the 8-bit bus CPU.
// Contents:
//   OP_*       4-bit opcode constants (instruction register bits [7:4])
//   state_t    controller state (ST_RST / ST_RUN / ST_HALT)
//   ctrl_t     packed bundle of every control strobe (*_n active low, alu_sub active high)
//   CTRL_IDLE  all strobes inactive
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_read_n;
    logic pc_write_n;
    logic pc_inc_n;
    logic mar_write_n;
    logic ram_read_n;
    logic ram_write_n;
    logic ir_read_n;
    logic ir_write_n;
    logic a_read_n;
    logic a_write_n;
    logic b_write_n;
    logic alu_read_n;
    logic alu_sub;
    logic out_write_n;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_read_n:   1'b1,
    pc_write_n:  1'b1,
    pc_inc_n:    1'b1,
    mar_write_n: 1'b1,
    ram_read_n:  1'b1,
    ram_write_n: 1'b1,
    ir_read_n:   1'b1,
    ir_write_n:  1'b1,
    a_read_n:    1'b1,
    a_write_n:   1'b1,
    b_write_n:   1'b1,
    alu_read_n:  1'b1,
    alu_sub:     1'b0,
    out_write_n: 1'b1
  };

endpackage

// File: rtl/microcode_controller_if.sv
// rtl/microcode_controller_if.sv - controller <-> datapath signal bundle
//
// Purpose: groups the instruction/flag inputs and all strobe outputs of the
// microcode controller.
// Modports:
//   slave  - the controller: reads i_instr/flags, drives o_* strobes, o_halt, o_step
//   master - the datapath side: drives i_instr/flags, observes the strobes
interface microcode_controller_if #(
  parameter int STEP_W = 3
);

  logic [7:0]        i_instr;
  logic              i_flag_carry;
  logic              i_flag_zero;
  logic              o_halt;
  logic              o_pc_read_n;
  logic              o_pc_write_n;
  logic              o_pc_inc_n;
  logic              o_mar_write_n;
  logic              o_ram_read_n;
  logic              o_ram_write_n;
  logic              o_ir_read_n;
  logic              o_ir_write_n;
  logic              o_a_read_n;
  logic              o_a_write_n;
  logic              o_b_write_n;
  logic              o_alu_read_n;
  logic              o_alu_sub;
  logic              o_out_write_n;
  logic [STEP_W-1:0] o_step;

  modport slave (
    input  i_instr, i_flag_carry, i_flag_zero,
    output o_halt, o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_write_n,
           o_ram_read_n, o_ram_write_n, o_ir_read_n, o_ir_write_n,
           o_a_read_n, o_a_write_n, o_b_write_n, o_alu_read_n, o_alu_sub,
           o_out_write_n, o_step
  );

  modport master (
    output i_instr, i_flag_carry, i_flag_zero,
    input  o_halt, o_pc_read_n, o_pc_write_n, o_pc_inc_n, o_mar_write_n,
           o_ram_read_n, o_ram_write_n, o_ir_read_n, o_ir_write_n,
           o_a_read_n, o_a_write_n, o_b_write_n, o_alu_read_n, o_alu_sub,
           o_out_write_n, o_step
  );

endinterface

// File: rtl/microcode_controller_decode.sv
// rtl/microcode_controller_decode.sv - combinational micro-step decoder
//
// Purpose: maps (micro-step, opcode, flags) to the control strobe bundle.
// Ports:
//   step        in   current micro-step
//   opcode      in   instruction register bits [7:4]
//   flag_carry  in   registered ALU carry flag
//   flag_zero   in   registered ALU zero flag
//   ctrl        out  strobes for this step (CTRL_IDLE when nothing to do)
//   last        out  this step retires the instruction
//   halt_req    out  HLT execute step: controller should enter HALT
module microcode_controller_decode
  import cpu_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        opcode,
  input  logic              flag_carry,
  input  logic              flag_zero,
  output ctrl_t             ctrl,
  output logic              last,
  output logic              halt_req
);

  always_comb begin
    ctrl     = CTRL_IDLE;
    last     = 1'b0;
    halt_req = 1'b0;

    if (step == STEP_W'(0)) begin
      ctrl.pc_read_n   = 1'b0;
      ctrl.mar_write_n = 1'b0;
    end else if (step == STEP_W'(1)) begin
      ctrl.ram_read_n = 1'b0;
      ctrl.ir_write_n = 1'b0;
      ctrl.pc_inc_n   = 1'b0;
    end else if (step == STEP_W'(2)) begin
      case (opcode)
        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
          ctrl.ir_read_n   = 1'b0;
          ctrl.mar_write_n = 1'b0;
        end
        OP_LDI: begin
          ctrl.ir_read_n = 1'b0;
          ctrl.a_write_n = 1'b0;
          last           = 1'b1;
        end
        OP_JMP: begin
          ctrl.ir_read_n  = 1'b0;
          ctrl.pc_write_n = 1'b0;
          last            = 1'b1;
        end
        // Conditional jumps retire at T2 whether taken or not.
        OP_JC: begin
          ctrl.ir_read_n  = ~flag_carry;
          ctrl.pc_write_n = ~flag_carry;
          last            = 1'b1;
        end
        OP_JZ: begin
          ctrl.ir_read_n  = ~flag_zero;
          ctrl.pc_write_n = ~flag_zero;
          last            = 1'b1;
        end
        OP_OUT: begin
          ctrl.a_read_n    = 1'b0;
          ctrl.out_write_n = 1'b0;
          last             = 1'b1;
        end
        OP_HLT: begin
          halt_req = 1'b1;
          last     = 1'b1;
        end
        default: last = 1'b1;   // NOP and unused opcodes 9-D
      endcase
    end else if (step == STEP_W'(3)) begin
      case (opcode)
        OP_LDA: begin
          ctrl.ram_read_n = 1'b0;
          ctrl.a_write_n  = 1'b0;
          last            = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          ctrl.ram_read_n = 1'b0;
          ctrl.b_write_n  = 1'b0;
          ctrl.alu_sub    = (opcode == OP_SUB);
        end
        OP_STA: begin
          ctrl.a_read_n    = 1'b0;
          ctrl.ram_write_n = 1'b0;
          last             = 1'b1;
        end
        default: last = 1'b1;
      endcase
    end else if (step == STEP_W'(4)) begin
      case (opcode)
        OP_ADD, OP_SUB: begin
          ctrl.alu_read_n = 1'b0;
          ctrl.a_write_n  = 1'b0;
          ctrl.alu_sub    = (opcode == OP_SUB);
          last            = 1'b1;
        end
        default: last = 1'b1;
      endcase
    end else begin
      last = 1'b1;
    end
  end

endmodule

// File: rtl/microcode_controller.sv
// rtl/microcode_controller.sv - fetch/execute microcode sequencer for the 8-bit bus CPU
//
// Purpose: holds the controller state (RST/RUN/HALT) and the micro-step
// counter, and gates the decoded strobes onto the datapath.
// Ports:
//   i_clk    in   system clock
//   i_reset  in   synchronous active-low reset
//   i_step   in   single-step pulse (only with CONTROLLER_SINGLE_STEP_EN)
//   bus      slave modport: i_instr/i_flag_* in, all strobes, o_halt, o_step out
// Build option: CONTROLLER_SINGLE_STEP_EN - each i_step pulse runs one instruction.
module microcode_controller
  import cpu_pkg::*;
#(
  parameter int STEP_W    = 3,
  parameter int LAST_STEP = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
`ifdef CONTROLLER_SINGLE_STEP_EN
  input  logic                  i_step,
`endif
  microcode_controller_if.slave bus
);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  ctrl_t             dec_ctrl, ctrl;
  logic              dec_last;
  logic              dec_halt;
  logic              hold;

`ifdef CONTROLLER_SINGLE_STEP_EN
  // go_q is set by an i_step pulse while parked at step 0 and cleared when
  // the instruction retires, so one pulse buys exactly one instruction.
  logic go_q, go_d;
  assign hold = (step_q == '0) && !go_q;
`else
  assign hold = 1'b0;
`endif

  microcode_controller_decode #(
    .STEP_W(STEP_W)
  ) u_decode (
    .step      (step_q),
    .opcode    (bus.i_instr[7:4]),
    .flag_carry(bus.i_flag_carry),
    .flag_zero (bus.i_flag_zero),
    .ctrl      (dec_ctrl),
    .last      (dec_last),
    .halt_req  (dec_halt)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ctrl    = CTRL_IDLE;
`ifdef CONTROLLER_SINGLE_STEP_EN
    go_d    = go_q;
`endif
    case (state_q)
      ST_RST: begin
        state_d = ST_RUN;
        step_d  = '0;
      end
      ST_RUN: begin
        if (hold) begin
`ifdef CONTROLLER_SINGLE_STEP_EN
          if (i_step) go_d = 1'b1;
`endif
        end else begin
          ctrl = dec_ctrl;
          if (dec_halt) begin
            state_d = ST_HALT;   // step is frozen at the HLT execute step
          end else if (dec_last || (step_q >= STEP_W'(LAST_STEP))) begin
            step_d = '0;
`ifdef CONTROLLER_SINGLE_STEP_EN
            go_d   = 1'b0;
`endif
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ST_HALT: ;
      default: begin
        state_d = ST_RST;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_RST;
      step_q  <= '0;
`ifdef CONTROLLER_SINGLE_STEP_EN
      go_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
`ifdef CONTROLLER_SINGLE_STEP_EN
      go_q    <= go_d;
`endif
    end
  end

  assign bus.o_halt        = (state_q == ST_HALT);
  assign bus.o_step        = step_q;
  assign bus.o_pc_read_n   = ctrl.pc_read_n;
  assign bus.o_pc_write_n  = ctrl.pc_write_n;
  assign bus.o_pc_inc_n    = ctrl.pc_inc_n;
  assign bus.o_mar_write_n = ctrl.mar_write_n;
  assign bus.o_ram_read_n  = ctrl.ram_read_n;
  assign bus.o_ram_write_n = ctrl.ram_write_n;
  assign bus.o_ir_read_n   = ctrl.ir_read_n;
  assign bus.o_ir_write_n  = ctrl.ir_write_n;
  assign bus.o_a_read_n    = ctrl.a_read_n;
  assign bus.o_a_write_n   = ctrl.a_write_n;
  assign bus.o_b_write_n   = ctrl.b_write_n;
  assign bus.o_alu_read_n  = ctrl.alu_read_n;
  assign bus.o_alu_sub     = ctrl.alu_sub;
  assign bus.o_out_write_n = ctrl.out_write_n;

endmodule

// File: tb/tb_microcode_controller.sv
// tb/tb_microcode_controller.sv - scoreboard bench for microcode_controller
module tb_microcode_controller;

  // Active-high micro-op masks, one bit per strobe
  localparam logic [12:0] PCR  = 13'h0001;
  localparam logic [12:0] PCW  = 13'h0002;
  localparam logic [12:0] PCI  = 13'h0004;
  localparam logic [12:0] MARW = 13'h0008;
  localparam logic [12:0] RAMR = 13'h0010;
  localparam logic [12:0] RAMW = 13'h0020;
  localparam logic [12:0] IRR  = 13'h0040;
  localparam logic [12:0] IRW  = 13'h0080;
  localparam logic [12:0] AR   = 13'h0100;
  localparam logic [12:0] AW   = 13'h0200;
  localparam logic [12:0] BW   = 13'h0400;
  localparam logic [12:0] ALUR = 13'h0800;
  localparam logic [12:0] OUTW = 13'h1000;
  localparam logic [12:0] DRIVERS = PCR | RAMR | IRR | AR | ALUR;

  typedef struct packed {
    logic [12:0] act;
    logic        sub;
    logic        halt;
    logic [2:0]  step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic step_in;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  microcode_controller_if #(.STEP_W(3)) bus ();

  microcode_controller #(
    .STEP_W   (3),
    .LAST_STEP(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
`ifdef CONTROLLER_SINGLE_STEP_EN
    .i_step (step_in),
`endif
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a strobe set; compare it to the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    logic [12:0] act;
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = ~{bus.o_out_write_n, bus.o_alu_read_n, bus.o_b_write_n, bus.o_a_write_n,
              bus.o_a_read_n, bus.o_ir_write_n, bus.o_ir_read_n, bus.o_ram_write_n,
              bus.o_ram_read_n, bus.o_mar_write_n, bus.o_pc_inc_n, bus.o_pc_write_n,
              bus.o_pc_read_n};
      chk("strobes", 32'(act), 32'(e.act));
      chk("alu_sub", 32'(bus.o_alu_sub), 32'(e.sub));
      chk("halt", 32'(bus.o_halt), 32'(e.halt));
      chk("step", 32'(bus.o_step), 32'(e.step));
      chk("one_driver", 32'($countones(act & DRIVERS) <= 1), 32'd1);
    end
  end

  task automatic push(input logic [12:0] m, input logic s, input logic h, input int st);
    exp_q.push_back('{act: m, sub: s, halt: h, step: 3'(st)});
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      push(13'h0, 1'b0, 1'b0, 0);
      if (i == n - 1) rst_n = 1'b1;
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      push(13'h0, 1'b0, 1'b1, 2);
      if (i == n - 1) rst_n = 1'b0;
    end
  endtask

  // Reference: the instruction's micro-op list per cycle, from T0 to retirement.
  // abort_at >= 0 asserts reset during that step and returns.
  task automatic run_instr(input logic [7:0] ins, input logic c, input logic z, input int abort_at);
    logic [12:0] m[5];
    logic        s[5];
    int          last;
    logic [3:0]  op;
    op = ins[7:4];
    for (int i = 0; i < 5; i++) begin m[i] = '0; s[i] = 1'b0; end
    m[0] = PCR | MARW;
    m[1] = RAMR | IRW | PCI;
    last = 2;
    case (op)
      4'h1: begin m[2] = IRR | MARW; m[3] = RAMR | AW; last = 3; end
      4'h2, 4'h3: begin
        m[2] = IRR | MARW; m[3] = RAMR | BW; m[4] = ALUR | AW; last = 4;
        s[3] = (op == 4'h3); s[4] = (op == 4'h3);
      end
      4'h4: begin m[2] = IRR | MARW; m[3] = AR | RAMW; last = 3; end
      4'h5: m[2] = IRR | AW;
      4'h6: m[2] = IRR | PCW;
      4'h7: m[2] = c ? (IRR | PCW) : 13'h0;
      4'h8: m[2] = z ? (IRR | PCW) : 13'h0;
      4'hE: m[2] = AR | OUTW;
      default: m[2] = 13'h0;
    endcase
`ifdef CONTROLLER_SINGLE_STEP_EN
    @(posedge clk); #1;
    bus.i_instr = ins; bus.i_flag_carry = c; bus.i_flag_zero = z;
    step_in = 1'b1;
    push(13'h0, 1'b0, 1'b0, 0);
`endif
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.i_instr = ins; bus.i_flag_carry = c; bus.i_flag_zero = z;
        step_in = 1'b0;
      end
      push(m[i], s[i], 1'b0, i);
      if (i == abort_at) begin
        rst_n = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    step_in = 1'b0;
    bus.i_instr = 8'h00;
    bus.i_flag_carry = 1'b0;
    bus.i_flag_zero = 1'b0;

    reset_cycles(3);
    run_instr(8'h1A, 1'b0, 1'b0, -1);
    run_instr(8'h3B, 1'b0, 1'b0, -1);
    run_instr(8'h75, 1'b0, 1'b0, -1);
    run_instr(8'h75, 1'b1, 1'b0, -1);
    run_instr(8'h84, 1'b0, 1'b1, -1);
    run_instr(8'h27, 1'b0, 1'b0, 3);
    reset_cycles(1);

    for (int k = 0; k < 80; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, 1'($urandom), 1'($urandom), -1);
    end

    run_instr(8'hF0, 1'b0, 1'b0, -1);
    halt_hold(20);
    reset_cycles(2);
    run_instr(8'h4C, 1'b0, 1'b0, -1);
    run_instr(8'hE0, 1'b0, 1'b0, -1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
